mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous unified RAM between the fetch port (PCF/instr read)
//  and the data port (ALUResultM/WriteDataM/byteEnable) of the riscv core.
//  Replaces the separate imem/dmem pair at top level.
//  Data port has priority; a starvation counter guarantees fetch progress.
//  Read data returns one cycle after grant and is routed back to the owning requester.
// PARAMETERS
//  ADDR_W      10  RAM word-address width; mem_addr = byte_addr[ADDR_W+1:2]
//  MAX_STREAK  4   consecutive cycles fetch may be denied before it is forced through (>=1)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  clr         in   1      synchronous active-high reset
//  if_req      in   1      fetch read request
//  if_addr     in   32     fetch byte address (PCF)
//  if_gnt      out  1      fetch request accepted this cycle
//  if_rvalid   out  1      if_rdata valid this cycle
//  if_rdata    out  32     fetched instruction
//  d_req       in   1      data request (read or write)
//  d_we        in   1      1 = write, 0 = read
//  d_be        in   4      byte enables for write (byteEnable)
//  d_addr      in   32     data byte address (ALUResultM)
//  d_wdata     in   32     write data (WriteDataM)
//  d_gnt       out  1      data request accepted this cycle
//  d_rvalid    out  1      d_rdata valid this cycle (reads only)
//  d_rdata     out  32     load data
//  mem_en      out  1      RAM access enable
//  mem_we      out  1      RAM write enable
//  mem_be      out  4      RAM byte-lane write enables
//  mem_addr    out  ADDR_W RAM word address
//  mem_wdata   out  32     RAM write data
//  mem_rdata   in   32     RAM read data, valid 1 cycle after mem_en&~mem_we
// BEHAVIOUR
//  - Grant is combinational from requests and registered state; at most one grant per cycle.
//  - Arbitration: force = if_req & (starve_cnt == MAX_STREAK).
//    if force: if_gnt=1. else if d_req: d_gnt=1. else if if_req: if_gnt=1.
//  - mem_* driven combinationally from granted port; mem_en=0, mem_we=0, mem_be=0 when no grant.
//    mem_be = d_be on data write, 4'b0000 on any read.
//  - starve_cnt: +1 (saturating at MAX_STREAK) when if_req & ~if_gnt; cleared on if_gnt or ~if_req.
//  - Read-owner FSM (registered), states IDLE, IF_RD, D_RD:
//    next = IF_RD on if_gnt; D_RD on d_gnt & ~d_we; else IDLE. Transitions every cycle.
//  - if_rvalid = (state==IF_RD); d_rvalid = (state==D_RD).
//    if_rdata = d_rdata = mem_rdata (valid only with the respective rvalid).
//  - Write latency: committed on the grant edge, no response pulse.
//  - Back-to-back grants are allowed every cycle; a new grant may coincide with the previous rvalid.
//  - Requester holds req/addr/data stable until it sees gnt; the arbiter never retracts a grant.
//  - Address bits [1:0] are ignored; bits above ADDR_W+1 are ignored (aliasing wraps).
//  - Reset, including mid-operation: state=IDLE, starve_cnt=0.
//    In the cycle after clr, if_rvalid=d_rvalid=0 and any in-flight read response is dropped.
//    While clr is high, gnt outputs still follow arbitration, but the core is held in reset.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs perf_if_wait[31:0] and perf_d_wait[31:0].
//    Each counts cycles its req was high without gnt; wraps at 2^32; cleared by clr.
//  ARB_PERF_CNT_EN undefined: these ports and counters are absent; arbitration is identical.
// TESTING
//  1. if_req=1 only, if_addr=0x0,4,8 on consecutive cycles -> if_gnt each cycle;
//     if_rvalid with RAM words 0,1,2 one cycle later.
//  2. d_req=1, d_we=1, d_be=4'b0011, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x10;
//     a subsequent read of 0x40 returns old[31:16] with low half 0xBEEF.
//  3. if_req & d_req every cycle, MAX_STREAK=4 -> d_gnt for 4 cycles, then if_gnt for 1 cycle;
//     the pattern repeats.
//  4. Fetch read and data read granted on consecutive cycles -> if_rvalid, then d_rvalid,
//     each with the correct word; the other rvalid stays 0.
//  5. clr asserted in the cycle after a data-read grant -> d_rvalid=0 next cycle;
//     state IDLE; starve_cnt=0.
//  6. With ARB_PERF_CNT_EN defined: replay test 3 for 10 cycles -> perf_if_wait=8, perf_d_wait=2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter sharing one single-port synchronous RAM; data wins unless fetch has starved.
// Define ARB_PERF_CNT_EN to add the perf_if_wait / perf_d_wait wait-cycle counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
`endif
);

  localparam int CNT_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_IF_RD = 2'd1;
  localparam logic [1:0] S_D_RD  = 2'd2;

  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       state, state_nxt;
  logic             force_if;
  logic             d_wr;

  // Byte-offset and alias bits never reach the RAM.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         d_addr[31:ADDR_W+2], d_addr[1:0]};

  // Arbitration: a starved fetch overrides the data port for exactly one grant.
  assign force_if = if_req && (starve_cnt == STREAK_MAX);
  assign if_gnt   = force_if || (if_req && !d_req);
  assign d_gnt    = d_req && !force_if;
  assign d_wr     = d_gnt && d_we;

  always_comb begin
    mem_en    = if_gnt || d_gnt;
    mem_we    = d_wr;
    mem_be    = d_wr ? d_be : 4'b0000;
    mem_wdata = d_wr ? d_wdata : 32'h0;
    mem_addr  = '0;
    if (d_gnt)       mem_addr = d_addr[ADDR_W+1:2];
    else if (if_gnt) mem_addr = if_addr[ADDR_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (clr)
      starve_cnt <= '0;
    else if (if_req && !if_gnt)
      starve_cnt <= (starve_cnt == STREAK_MAX) ? starve_cnt : starve_cnt + CNT_W'(1);
    else
      starve_cnt <= '0;
  end

  // Read-owner tracking: the RAM answers one cycle after a read grant.
  always_comb begin
    state_nxt = S_IDLE;
    if (if_gnt)              state_nxt = S_IF_RD;
    else if (d_gnt && !d_we) state_nxt = S_D_RD;
  end

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign if_rvalid = (state == S_IF_RD);
  assign d_rvalid  = (state == S_D_RD);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      perf_if_wait <= 32'h0;
      perf_d_wait  <= 32'h0;
    end else begin
      if (if_req && !if_gnt) perf_if_wait <= perf_if_wait + 32'd1;
      if (d_req && !d_gnt)   perf_d_wait  <= perf_d_wait + 32'd1;
    end
  end
`endif

endmodule
